// File: rtl/req_queue.sv
// rtl/req_queue.sv - first-word-fall-through request FIFO between SPI deserializer and control FSM
module req_queue #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [OPCODEW-1:0]         in_opcode,
  input  logic [ADDRW-1:0]           in_key_addr,
  input  logic [ADDRW-1:0]           in_text_addr,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OPCODEW-1:0]         out_opcode,
  output logic [ADDRW-1:0]           out_key_addr,
  output logic [ADDRW-1:0]           out_text_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = OPCODEW + 2 * ADDRW;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [WW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A push into a full queue is still accepted when the head leaves in the same cycle.
  assign full = (count_q == FULL_CNT);
  assign pop  = (count_q != '0) && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Storage is cleared on reset so the head outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_opcode, in_key_addr, in_text_addr};
    end
  end

  // Pointers wrap naturally at DEPTH; occupancy tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one of push/pop happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky record that a word was lost; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  // Outputs come straight from registers; ready keeps one slot for the word already in flight.
  always_comb begin
    {out_opcode, out_key_addr, out_text_addr} = mem[rd_ptr];
    out_valid = (count_q != '0);
    in_ready  = (count_q <= READY_MAX);
    count     = count_q;
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_req_queue.sv
// tb/tb_req_queue.sv - randomized self-checking bench for req_queue against a queue model
module tb_req_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] in_opcode;
  logic [7:0] in_key_addr;
  logic [7:0] in_text_addr;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_opcode;
  logic [7:0] out_key_addr;
  logic [7:0] out_text_addr;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] count;
  logic       overflow;

  int vectors;
  int miscompares;

  logic [17:0] mq[$];
  logic        m_ovf;

  req_queue #(.ADDRW(8), .OPCODEW(2), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_opcode(in_opcode), .in_key_addr(in_key_addr), .in_text_addr(in_text_addr),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_opcode(out_opcode), .out_key_addr(out_key_addr), .out_text_addr(out_text_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance the model, then sample 1 ns after the edge.
  task automatic cycle(input logic iv, input logic [1:0] op, input logic [7:0] k,
                       input logic [7:0] t, input logic ordy);
    logic mpop;
    logic mpush;
    in_valid = iv; in_opcode = op; in_key_addr = k; in_text_addr = t; out_ready = ordy;
    mpop  = (mq.size() != 0) && ordy;
    mpush = iv && ((mq.size() < DEPTH) || mpop);
    @(posedge clk); #1;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back({op, k, t});
    else if (iv) m_ovf = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: count=%0d out_valid=%b in_ready=%b overflow=%b, want 0/0/1/0",
               count, out_valid, in_ready, overflow);
    end
    vectors++;
    if ({out_opcode, out_key_addr, out_text_addr} !== 18'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {out_opcode, out_key_addr, out_text_addr});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  task automatic test_basic();
    cycle(1'b1, 2'b01, 8'h10, 8'h20, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || count !== 3'd1 || out_opcode !== 2'b01 ||
        out_key_addr !== 8'h10 || out_text_addr !== 8'h20) begin
      miscompares++;
      $display("FAIL basic_push: valid=%b count=%0d op=%b key=%h text=%h, want 1/1/01/10/20",
               out_valid, count, out_opcode, out_key_addr, out_text_addr);
    end
    cycle(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    vectors++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL basic_pop: valid=%b count=%0d, want 0/0", out_valid, count);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 8'(8'h30 + i), 8'(8'h40 + i), 1'b0);
    vectors++;
    if (count !== 3'd3 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_three: count=%0d in_ready=%b, want 3/0", count, in_ready);
    end
    cycle(1'b1, 2'd3, 8'h33, 8'h43, 1'b0);
    vectors++;
    if (count !== 3'd4 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_four: count=%0d overflow=%b, want 4/0", count, overflow);
    end
    cycle(1'b1, 2'd2, 8'hAA, 8'hBB, 1'b0);
    vectors++;
    if (count !== 3'd4 || overflow !== 1'b1 || out_key_addr !== 8'h30) begin
      miscompares++;
      $display("FAIL fill_drop: count=%0d overflow=%b head_key=%h, want 4/1/30",
               count, overflow, out_key_addr);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_key_addr !== 8'(8'h30 + i) || out_text_addr !== 8'(8'h40 + i)) begin
        miscompares++;
        $display("FAIL fill_drain%0d: key=%h text=%h, want %h/%h",
                 i, out_key_addr, out_text_addr, 8'(8'h30 + i), 8'(8'h40 + i));
      end
      cycle(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    end
    vectors++;
    if (count !== 3'd0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_sticky: count=%0d overflow=%b, want 0/1", count, overflow);
    end
  endtask

  task automatic test_simul_full();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd1, 8'(8'h50 + i), 8'h00, 1'b0);
    cycle(1'b1, 2'd2, 8'h5F, 8'h11, 1'b1);
    vectors++;
    if (count !== 3'd4 || overflow !== 1'b0 || out_key_addr !== 8'h51) begin
      miscompares++;
      $display("FAIL simul_full: count=%0d overflow=%b head_key=%h, want 4/0/51",
               count, overflow, out_key_addr);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    vectors++;
    if (mq.size() != 0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL simul_full_drain: count=%0d, want 0", count);
    end
  endtask

  task automatic test_simul_empty();
    do_reset();
    cycle(1'b1, 2'd3, 8'h77, 8'h88, 1'b1);
    vectors++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_key_addr !== 8'h77) begin
      miscompares++;
      $display("FAIL simul_empty_store: count=%0d valid=%b key=%h, want 1/1/77",
               count, out_valid, out_key_addr);
    end
    cycle(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL simul_empty_pop: count=%0d valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_order_wrap();
    logic [7:0] got[$];
    int next_key;
    int budget;
    logic [31:0] r;
    do_reset();
    next_key = 0;
    budget = 0;
    while (got.size() < 10 && budget < 300) begin
      r = $urandom;
      if (out_valid && r[0]) got.push_back(out_key_addr);
      if (next_key < 10 && r[1] && in_ready) begin
        cycle(1'b1, r[5:4], 8'(next_key), r[15:8], r[0]);
        next_key++;
      end else begin
        cycle(1'b0, 2'd0, 8'd0, 8'd0, r[0]);
      end
      budget++;
    end
    vectors++;
    if (got.size() != 10) begin
      miscompares++;
      $display("FAIL order_timeout: popped %0d words, want 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      vectors++;
      if (got[i] !== 8'(i)) begin
        miscompares++;
        $display("FAIL order_word%0d: key=%h want %h", i, got[i], 8'(i));
      end
    end
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL order_final: count=%0d valid=%b, want 0/0", count, out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [31:0] d;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      d = $urandom;
      cycle(r[2:0] < 3'd5, d[1:0], d[9:2], d[17:10], r[4:3] != 2'b00);
      vectors++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() <= DEPTH - 2) || overflow !== m_ovf) begin
        miscompares++;
        $display("FAIL random_flags@%0d: count=%0d valid=%b in_ready=%b ovf=%b, want %0d/%b/%b/%b",
                 n, count, out_valid, in_ready, overflow, mq.size(), mq.size() != 0,
                 mq.size() <= DEPTH - 2, m_ovf);
      end
      if (mq.size() != 0) begin
        vectors++;
        if ({out_opcode, out_key_addr, out_text_addr} !== mq[0]) begin
          miscompares++;
          $display("FAIL random_head@%0d: got %h want %h",
                   n, {out_opcode, out_key_addr, out_text_addr}, mq[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd1, 8'(i), 8'(i), 1'b0);
    cycle(1'b0, 2'd0, 8'd0, 8'd0, 1'b1);
    vectors++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: count=%0d overflow=%b, want 3/1", count, overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: count=%0d valid=%b in_ready=%b overflow=%b, want 0/0/1/0",
               count, out_valid, in_ready, overflow);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mq.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    m_ovf = 1'b0;
    rst_n = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_key_addr = '0; in_text_addr = '0; out_ready = 1'b0;
    #3;
    test_reset();
    test_basic();
    test_fill();
    test_simul_full();
    test_simul_empty();
    test_order_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
